conv3x3_sobel: RTL and testbench

CONV3X3_SOBEL -- requirements
Module: conv3x3_sobel

---
 rtl/conv3x3_sobel.sv | 143 ++++++++++++++
 tb/tb_conv3x3_sobel.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conv3x3_sobel.sv
// 3x3 Sobel edge filter: 3-stage pipeline with column/line tracking and border forcing.
// Define SOBEL_THRESHOLD_EN to binarize the output against THRESH instead of mag[6:3].
module conv3x3_sobel #(
   parameter int N      = 399,
   parameter int ROWS   = 398,
   parameter int THRESH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [35:0] pixel_in,
   input  logic        wr_sig,
   output logic [3:0]  pixel_out,
   output logic        valid_out,
   output logic        frame_done
);

   localparam int              RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [8:0]      COL_LAST = 9'(N);
   localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

   generate
      if (N < 1 || N > 511 || ROWS < 1 || THRESH < 0 || THRESH > 127) begin : g_bad_param
         $error("conv3x3_sobel: parameter out of range");
      end
   endgenerate

   // p + 2q + r, at most 60
   function automatic logic [5:0] wsum(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   function automatic logic [5:0] absdiff(input logic [5:0] a, input logic [5:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   logic [3:0]    p [3][3];
   logic [5:0]    gxp_q, gxn_q, gyp_q, gyn_q, gxp_d, gxn_d, gyp_d, gyn_d;
   logic [5:0]    agx_q, agy_q, agx_d, agy_d;
   logic          v1_q, v2_q, v1_d, v2_d;
   logic [6:0]    mag;
   logic [3:0]    pix_map;
   logic [3:0]    pixel_q, pixel_d;
   logic          valid_q, valid_d, frame_q, frame_d;
   logic [8:0]    col_q, col_d;
   logic [RW-1:0] row_q, row_d;

`ifdef SOBEL_THRESHOLD_EN
   localparam logic [6:0] THRESH_V = 7'(THRESH);
`endif

   always_comb begin
      for (int unsigned r = 0; r < 3; r++) begin
         for (int unsigned c = 0; c < 3; c++) begin
            p[r][c] = pixel_in[35 - 12*r - 4*c -: 4];
         end
      end
   end

   always_comb begin
      v1_d    = wr_sig;
      v2_d    = v1_q;
      valid_d = v2_q;
      gxp_d   = gxp_q;
      gxn_d   = gxn_q;
      gyp_d   = gyp_q;
      gyn_d   = gyn_q;
      agx_d   = agx_q;
      agy_d   = agy_q;
      pixel_d = pixel_q;
      frame_d = 1'b0;
      col_d   = col_q;
      row_d   = row_q;

      if (wr_sig) begin
         gxp_d = wsum(p[0][2], p[1][2], p[2][2]);
         gxn_d = wsum(p[0][0], p[1][0], p[2][0]);
         gyp_d = wsum(p[2][0], p[2][1], p[2][2]);
         gyn_d = wsum(p[0][0], p[0][1], p[0][2]);
      end

      if (v1_q) begin
         agx_d = absdiff(gxp_q, gxn_q);
         agy_d = absdiff(gyp_q, gyn_q);
      end

      mag = {1'b0, agx_q} + {1'b0, agy_q};
`ifdef SOBEL_THRESHOLD_EN
      pix_map = (mag >= THRESH_V) ? 4'hF : 4'h0;
`else
      pix_map = 4'(mag >> 3);
`endif

      // col_q/row_q name the output being produced this cycle; they advance with it
      if (v2_q) begin
         pixel_d = (col_q == '0 || col_q == COL_LAST) ? '0 : pix_map;
         frame_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gxp_q   <= '0;
         gxn_q   <= '0;
         gyp_q   <= '0;
         gyn_q   <= '0;
         agx_q   <= '0;
         agy_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         pixel_q <= '0;
         valid_q <= 1'b0;
         frame_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         gxp_q   <= gxp_d;
         gxn_q   <= gxn_d;
         gyp_q   <= gyp_d;
         gyn_q   <= gyn_d;
         agx_q   <= agx_d;
         agy_q   <= agy_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         pixel_q <= pixel_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   assign pixel_out  = pixel_q;
   assign valid_out  = valid_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_conv3x3_sobel.sv
// Directed bench for conv3x3_sobel on a reduced 8x3 frame; expected outputs are hand-computed magnitudes.
module tb_conv3x3_sobel;

   localparam int N      = 7;
   localparam int ROWS   = 3;
   localparam int THRESH = 32;

   localparam logic [35:0] EDGE  = 36'h00F00F00F;  // Gx=60  Gy=0
   localparam logic [35:0] NEG   = 36'hF00F00F00;  // Gx=-60 Gy=0
   localparam logic [35:0] HORIZ = 36'h000000FFF;  // Gx=0   Gy=60
   localparam logic [35:0] UNI   = 36'h555555555;  // mag 0
   localparam logic [35:0] DIAG  = 36'h00F0FFFFF;  // Gx=Gy=45
   localparam logic [35:0] M30   = 36'h000008070;  // Gx=16 Gy=14
   localparam logic [35:0] M32   = 36'h000008080;  // Gx=16 Gy=16

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [35:0] pixel_in = '0;
   logic        wr_sig = 1'b0;
   logic [3:0]  pixel_out;
   logic        valid_out;
   logic        frame_done;

   always #5 clk = ~clk;

   conv3x3_sobel #(.N(N), .ROWS(ROWS), .THRESH(THRESH)) dut (
      .clk        (clk),
      .reset      (reset),
      .pixel_in   (pixel_in),
      .wr_sig     (wr_sig),
      .pixel_out  (pixel_out),
      .valid_out  (valid_out),
      .frame_done (frame_done)
   );

   typedef struct {
      logic       v;
      logic [3:0] pix;
      logic       fd;
   } exp_t;

   int         passed = 0;
   int         total = 0;
   exp_t       q[$];
   int         bcol = 0;
   int         brow = 0;
   logic [3:0] last_pix = '0;
   int         obs_valids = 0;
   int         obs_fds = 0;

   function automatic logic [3:0] exp_map(input int mag);
`ifdef SOBEL_THRESHOLD_EN
      return (mag >= THRESH) ? 4'hF : 4'h0;
`else
      return 4'(mag / 8);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      exp_t idle;
      idle.v = 1'b0; idle.pix = '0; idle.fd = 1'b0;
      q.delete();
      q.push_back(idle);
      q.push_back(idle);
      bcol = 0;
      brow = 0;
      last_pix = '0;
      obs_valids = 0;
      obs_fds = 0;
   endtask

   // Drive one cycle at a falling edge, then check the output due from two drives earlier.
   task automatic step(input logic w, input logic [35:0] pix, input int mag, input string tag);
      exp_t e;
      logic [3:0] want;
      wr_sig   = w;
      pixel_in = pix;
      e.v = w; e.pix = '0; e.fd = 1'b0;
      if (w) begin
         e.pix = (bcol == 0 || bcol == N) ? 4'h0 : exp_map(mag);
         e.fd  = (bcol == N) && (brow == ROWS - 1);
         if (bcol == N) begin
            bcol = 0;
            brow = (brow == ROWS - 1) ? 0 : brow + 1;
         end else begin
            bcol++;
         end
      end
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      want = e.v ? e.pix : last_pix;
      if (e.v) last_pix = e.pix;
      if (valid_out === 1'b1) obs_valids++;
      if (frame_done === 1'b1) obs_fds++;
      chk($sformatf("%s valid_out", tag), 32'(valid_out), 32'(e.v));
      chk($sformatf("%s pixel_out", tag), 32'(pixel_out), 32'(want));
      chk($sformatf("%s frame_done", tag), 32'(frame_done), 32'(e.fd));
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, '0, 0, tag);
   endtask

   initial begin
      reset    = 1'b0;
      wr_sig   = 1'b1;
      pixel_in = EDGE;
      repeat (3) @(negedge clk);
      chk("reset valid_out", 32'(valid_out), 32'h0);
      chk("reset pixel_out", 32'(pixel_out), 32'h0);
      chk("reset frame_done", 32'(frame_done), 32'h0);

      wr_sig = 1'b0;
      model_reset();
      reset = 1'b1;
      idle(3, "post_reset_idle");

      // Row 0: isolated windows, one per column
      step(1'b1, EDGE, 60, "c0_edge_border");   idle(3, "gap");
      step(1'b1, EDGE, 60, "c1_edge");          idle(3, "gap");
      step(1'b1, UNI, 0, "c2_uniform");         idle(3, "gap");
      step(1'b1, DIAG, 90, "c3_diag");          idle(3, "gap");
      step(1'b1, NEG, 60, "c4_neg_edge");       idle(3, "gap");
      step(1'b1, M30, 30, "c5_mag30");          idle(3, "gap");
      step(1'b1, M32, 32, "c6_mag32");          idle(3, "gap");
      step(1'b1, HORIZ, 60, "c7_horiz_border"); idle(3, "gap");

      // Row 1: back-to-back line
      for (int c = 0; c <= N; c++) step(1'b1, HORIZ, 60, $sformatf("r1_c%0d", c));
      // Row 2: random bubbles, frame_done on the last output
      for (int c = 0; c <= N; c++) begin
         step(1'b1, DIAG, 90, $sformatf("r2_c%0d", c));
         idle($urandom_range(1, 3), "r2_gap");
      end
      idle(3, "frame_end");

      // Counters wrapped: next frame starts at col 0
      step(1'b1, DIAG, 90, "wrap_c0");
      step(1'b1, DIAG, 90, "wrap_c1");
      step(1'b1, EDGE, 60, "wrap_c2");
      step(1'b1, EDGE, 60, "wrap_c3");
      step(1'b1, EDGE, 60, "wrap_c4");

      // Mid-line reset with windows in flight
      wr_sig = 1'b0;
      reset  = 1'b0;
      #1;
      chk("async_reset valid_out", 32'(valid_out), 32'h0);
      chk("async_reset pixel_out", 32'(pixel_out), 32'h0);
      chk("async_reset frame_done", 32'(frame_done), 32'h0);
      repeat (2) @(negedge clk);
      model_reset();
      reset = 1'b1;
      idle(4, "post_midreset_idle");

      // Full frame after reset: one frame_done on output 24 only
      for (int i = 0; i < (N + 1) * ROWS; i++) begin
         step(1'b1, EDGE, 60, $sformatf("frame_w%0d", i));
         if (i % 5 == 2) idle(1, "frame_gap");
      end
      idle(4, "drain");
      chk("frame valid count", 32'(obs_valids), 32'((N + 1) * ROWS));
      chk("frame_done count", 32'(obs_fds), 32'h1);

      step(1'b1, EDGE, 60, "next_frame_c0");
      idle(3, "tail");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
